port_power_detector: RTL
========================

Name: port_power_detector

Overview:
- Measurement-side counterpart of the sweep stimulus port: consumes the digitised I/Q stream returned from the device-under-test port and reduces it to one averaged power word per sweep point.
- Sits between the receive ADC/downconverter stream and the sweep result store; also tracks the peak-power point, for passband centre detection on filter benches.
- Discards a settling window after every point step, integrates |I|^2+|Q|^2 over 2^LOG2_N samples, emits the result over a valid/ready handshake.

Parameters:
- DW, 12, signed I/Q sample width.
- LOG2_N, 4, log2 of samples averaged per point (N = 2^LOG2_N).
- NPTS, 64, sweep points per run (>=1).
- SETTLE, 8, accepted samples discarded at start of each point (0 allowed).
- IW = clog2(NPTS) (derived, min 1), index width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin sweep; sampled only in IDLE.
- s_valid  in  1  input sample valid.
- s_i  in  DW  signed in-phase sample.
- s_q  in  DW  signed quadrature sample.
- s_ready  out  1  sample accepted when s_valid&s_ready.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_power  out  2*DW  unsigned averaged power.
- m_index  out  IW  sweep point of m_power.
- m_last  out  1  m_index == NPTS-1, qualified by m_valid.
- busy  out  1  high in any state but IDLE.
- done  out  1  one-cycle pulse at sweep completion.
- peak_index  out  IW  point of max power so far.
- peak_power  out  2*DW  max power so far.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters, accumulator, index, peak cleared.
- States IDLE, SETTLE, ACCUM, EMIT.
- IDLE: s_ready=0. start=1 -> index=0, peak_index/peak_power cleared to 0 -> SETTLE (or ACCUM if SETTLE=0). start outside IDLE ignored.
- SETTLE: s_ready=1; count accepted samples; samples discarded; after SETTLE-th accept -> ACCUM with accumulator 0. Cycles with s_valid=0 do not count.
- ACCUM: s_ready=1; per accept acc += s_i*s_i + s_q*s_q (full precision, acc width 2*DW+LOG2_N, no overflow possible). On N-th accept: m_power <= (acc + final term) >> LOG2_N (truncate), m_valid <= 1 next cycle, -> EMIT. Latency: m_valid high the cycle after the N-th accept.
- Peak updated in same edge as m_power latch: if new power > peak_power (strict; ties keep earlier index), or index==0, load peak_index/peak_power.
- EMIT: s_ready=0; m_valid, m_power, m_index, m_last held stable until m_valid&m_ready. On handshake m_valid drops next cycle; if index==NPTS-1 -> IDLE, done=1 for exactly the following cycle, busy=0; else index+1 -> SETTLE.
- m_ready may be high before m_valid; no combinational path from m_ready to s_ready or m_valid.
- Peak outputs hold after done until next start.
- Reset mid-sweep: immediate abort, no done, no partial result; next start begins at index 0.
- NPTS=1: single point, m_last=1 on its result.

Test Plan:
- DW=12, LOG2_N=4, SETTLE=8, NPTS=4, constant I=3 Q=4, s_valid=1, m_ready=1 -> four results power 25, index 0..3, 24 accepts per point, m_last only on index 3, done one cycle after last handshake, busy low same cycle.
- Constant I=-2048 Q=-2048 -> m_power 8388608 (2^23), no wrap; peak_power 8388608.
- Settle discard: per point first 8 samples I=Q=2047, remaining 16 zero -> m_power 0 every point.
- Backpressure: hold m_ready low 10 cycles at index 1 -> m_valid, m_power, m_index stable, s_ready 0, upstream samples not consumed; release -> proceeds to index 2.
- Peak: point powers 25,100,100,9 with random s_valid gaps -> peak_index 1, peak_power 100 at done; averages unaffected by gaps.
- Reset pulse mid ACCUM of index 2 -> all outputs 0 same cycle, no done; start ignored while busy; fresh start produces index 0 first.

Source files
------------

// File: rtl/port_power_detector_if.sv
// Receive I/Q sample stream into the detector and averaged-power result stream out of it.
// The slave modport is the detector side; the master modport is the producer/consumer side.
interface port_power_detector_if #(
    parameter int DW   = 12,
    parameter int NPTS = 64
);
    localparam int IW = (NPTS > 1) ? $clog2(NPTS) : 1;

    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_i;
    logic signed [DW-1:0] s_q;
    logic                 m_valid;
    logic                 m_ready;
    logic [2*DW-1:0]      m_power;
    logic [IW-1:0]        m_index;
    logic                 m_last;

    modport master (
        output s_valid, s_i, s_q, m_ready,
        input  s_ready, m_valid, m_power, m_index, m_last
    );

    modport slave (
        input  s_valid, s_i, s_q, m_ready,
        output s_ready, m_valid, m_power, m_index, m_last
    );
endinterface

// File: rtl/port_power_detector.sv
// Per-sweep-point power detector: drops a settling window, averages |I|^2+|Q|^2 over
// 2^LOG2_N samples, hands one power word per point downstream and tracks the peak point.
module port_power_detector #(
    parameter int DW     = 12,
    parameter int LOG2_N = 4,
    parameter int NPTS   = 64,
    parameter int SETTLE = 8,
    localparam int IW    = (NPTS > 1) ? $clog2(NPTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    port_power_detector_if.slave  s,
    output logic                  busy,
    output logic                  done,
    output logic [IW-1:0]         peak_index,
    output logic [2*DW-1:0]       peak_power
);
    localparam int PW = 2 * DW;
    localparam int AW = PW + LOG2_N;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW = ((SW > LOG2_N) ? SW : LOG2_N) + 1;

    localparam logic [CW-1:0] SETTLE_LAST = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;
    localparam logic [CW-1:0] ACCUM_LAST  = CW'((1 << LOG2_N) - 1);
    localparam logic [IW-1:0] LAST_INDEX  = IW'(NPTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM,
        ST_EMIT
    } state_t;

    // With no settling window a point goes straight to integration.
    localparam state_t POINT_ENTRY = (SETTLE > 0) ? ST_SETTLE : ST_ACCUM;

    function automatic logic [PW-1:0] sample_power(input logic signed [DW-1:0] i,
                                                   input logic signed [DW-1:0] q);
        logic signed [PW-1:0] iw;
        logic signed [PW-1:0] qw;
        logic signed [PW-1:0] ii;
        logic signed [PW-1:0] qq;
        iw = PW'(i);
        qw = PW'(q);
        ii = iw * iw;
        qq = qw * qw;
        // Two squares of a DW-bit signed value top out at 2^(2*DW-1), so the sum fits PW bits.
        return $unsigned(ii) + $unsigned(qq);
    endfunction

    function automatic logic [PW-1:0] average(input logic [AW-1:0] acc);
        return acc[AW-1:LOG2_N];
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            m_valid_q, m_valid_d;
    logic [PW-1:0]   m_power_q, m_power_d;
    logic [IW-1:0]   m_index_q, m_index_d;
    logic            m_last_q, m_last_d;
    logic            done_q, done_d;
    logic [IW-1:0]   peak_index_q, peak_index_d;
    logic [PW-1:0]   peak_power_q, peak_power_d;

    logic            s_ready_int;
    logic            accept;
    logic [AW-1:0]   acc_sum;
    logic [PW-1:0]   point_power;

    assign s_ready_int = (state_q == ST_SETTLE) || (state_q == ST_ACCUM);
    assign accept      = s.s_valid && s_ready_int;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        m_valid_d    = m_valid_q;
        m_power_d    = m_power_q;
        m_index_d    = m_index_q;
        m_last_d     = m_last_q;
        done_d       = 1'b0;
        peak_index_d = peak_index_q;
        peak_power_d = peak_power_q;
        acc_sum      = acc_q + AW'(sample_power(s.s_i, s.s_q));
        point_power  = average(acc_sum);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d        = '0;
                    cnt_d        = '0;
                    acc_d        = '0;
                    peak_index_d = '0;
                    peak_power_d = '0;
                    state_d      = POINT_ENTRY;
                end
            end
            ST_SETTLE: begin
                if (accept) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = ST_ACCUM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    if (cnt_q == ACCUM_LAST) begin
                        cnt_d     = '0;
                        acc_d     = '0;
                        m_valid_d = 1'b1;
                        m_power_d = point_power;
                        m_index_d = idx_q;
                        m_last_d  = (idx_q == LAST_INDEX);
                        // Strict compare: on a tie the earlier point stays the peak.
                        if ((idx_q == '0) || (point_power > peak_power_q)) begin
                            peak_index_d = idx_q;
                            peak_power_d = point_power;
                        end
                        state_d = ST_EMIT;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (s.m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (idx_q == LAST_INDEX) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = POINT_ENTRY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            m_valid_q    <= 1'b0;
            m_power_q    <= '0;
            m_index_q    <= '0;
            m_last_q     <= 1'b0;
            done_q       <= 1'b0;
            peak_index_q <= '0;
            peak_power_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            m_valid_q    <= m_valid_d;
            m_power_q    <= m_power_d;
            m_index_q    <= m_index_d;
            m_last_q     <= m_last_d;
            done_q       <= done_d;
            peak_index_q <= peak_index_d;
            peak_power_q <= peak_power_d;
        end
    end

    assign s.s_ready  = s_ready_int;
    assign s.m_valid  = m_valid_q;
    assign s.m_power  = m_power_q;
    assign s.m_index  = m_index_q;
    assign s.m_last   = m_last_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign peak_index = peak_index_q;
    assign peak_power = peak_power_q;

endmodule
